// File: rtl/zeroskip_merge_pipe.sv
// Zero-skip compaction and 1/2/4-beat merge stage for the MAC activation path.
// Each beat keeps the first K non-zeros of every row; beats fill successive slot windows.
module zeroskip_merge_pipe #(
  parameter int M            = 8,
  parameter int DATA_W       = 8,
  parameter int GROUP_SIZE   = 16,
  parameter int GROUP_NZ_MAX = 8
) (
  input  logic                                 clk,
  input  logic                                 a_rst_n,
  input  logic                                 enable,
  input  logic [1:0]                           ratio_sel,
  input  logic                                 flush,
  input  logic [M*GROUP_SIZE-1:0]              znz_din,
  input  logic [GROUP_SIZE*DATA_W-1:0]         act_din,
  input  logic                                 in_vld_i,
  output logic                                 in_rdy_o,
  output logic [M*GROUP_NZ_MAX*DATA_W-1:0]     act_enc_dout,
  output logic                                 act_enc_vld_o,
  input  logic                                 act_enc_rdy_i,
  output logic                                 ovf_o
);

  localparam int CW = $clog2(GROUP_SIZE + 1);
  localparam int SW = (GROUP_NZ_MAX > 1) ? $clog2(GROUP_NZ_MAX) : 1;

  typedef logic [M-1:0][GROUP_NZ_MAX-1:0][DATA_W-1:0] vec_t;

  logic [GROUP_SIZE-1:0][DATA_W-1:0] act_v;
  logic [M-1:0][GROUP_SIZE-1:0]      znz_v;
  vec_t       acc_q, dout_q, comp, merged;
  logic [1:0] beat_cnt, ratio_q, sel_mode, mode, last_idx;
  logic       ovf_acc, ovf_q, vld_q, flush_pend, ovf_beat;
  logic [CW-1:0] k, off, cnt, sv, idx;
  logic       accept, last, flush_req, flush_emit;

  assign act_v = act_din;
  assign znz_v = znz_din;

  // The first beat of a vector uses the live selection; later beats use the latched mode.
  assign sel_mode = (ratio_sel == 2'd3) ? 2'd0 : ratio_sel;
  assign mode     = (beat_cnt == 2'd0) ? sel_mode : ratio_q;
  assign k        = CW'(GROUP_NZ_MAX) >> mode;
  assign off      = CW'(beat_cnt) * k;
  assign last_idx = (mode == 2'd2) ? 2'd3 : (mode == 2'd1) ? 2'd1 : 2'd0;

  assign in_rdy_o   = enable & a_rst_n & (~vld_q | act_enc_rdy_i);
  assign accept     = in_vld_i & in_rdy_o;
  assign last       = accept & (beat_cnt == last_idx);
  assign flush_req  = flush | flush_pend;
  assign flush_emit = in_rdy_o & flush_req & ~accept & (beat_cnt != 2'd0);

  always_comb begin
    comp     = '0;
    merged   = acc_q;
    ovf_beat = 1'b0;
    cnt      = '0;
    sv       = '0;
    idx      = '0;
    for (int r = 0; r < M; r++) begin
      cnt = '0;
      for (int j = 0; j < GROUP_SIZE; j++) begin
        if (znz_v[r][j]) begin
          if (cnt < k) comp[r][cnt[SW-1:0]] = act_v[j];
          cnt = cnt + CW'(1);
        end
      end
      if (cnt > k) ovf_beat = 1'b1;
      // Slot window [off, off+K) of this row receives the compacted beat.
      for (int s = 0; s < GROUP_NZ_MAX; s++) begin
        sv  = CW'(s);
        idx = sv - off;
        if (sv >= off && idx < k) merged[r][s] = comp[r][idx[SW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!a_rst_n) begin
      acc_q      <= '0;
      dout_q     <= '0;
      beat_cnt   <= 2'd0;
      ratio_q    <= 2'd0;
      ovf_acc    <= 1'b0;
      ovf_q      <= 1'b0;
      vld_q      <= 1'b0;
      flush_pend <= 1'b0;
    end else if (enable) begin
      if (act_enc_rdy_i) vld_q <= 1'b0;
      if (accept) begin
        if (beat_cnt == 2'd0) ratio_q <= sel_mode;
        // A flush arriving with a beat is deferred; a completing beat makes it moot.
        flush_pend <= flush_req & ~last;
        if (last) begin
          dout_q   <= merged;
          ovf_q    <= ovf_acc | ovf_beat;
          vld_q    <= 1'b1;
          beat_cnt <= 2'd0;
          acc_q    <= '0;
          ovf_acc  <= 1'b0;
        end else begin
          acc_q    <= merged;
          ovf_acc  <= ovf_acc | ovf_beat;
          beat_cnt <= beat_cnt + 2'd1;
        end
      end else if (flush_emit) begin
        dout_q     <= acc_q;
        ovf_q      <= ovf_acc;
        vld_q      <= 1'b1;
        beat_cnt   <= 2'd0;
        acc_q      <= '0;
        ovf_acc    <= 1'b0;
        flush_pend <= 1'b0;
      end else begin
        flush_pend <= flush_req & (beat_cnt != 2'd0);
      end
    end
  end

  assign act_enc_dout  = dout_q;
  assign act_enc_vld_o = vld_q;
  assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_zeroskip_merge_pipe.sv
// Scoreboard bench for zeroskip_merge_pipe: directed beats push expected vectors,
// a monitor pops and compares on every output handshake.
module tb_zeroskip_merge_pipe;

  localparam int M  = 8;
  localparam int DW = 8;
  localparam int GS = 16;
  localparam int NZ = 8;
  localparam int VW = M * NZ * DW;

  typedef logic [M-1:0][NZ-1:0][DW-1:0] vec_t;
  typedef struct { vec_t d; logic ovf; } exp_t;

  logic            clk = 1'b0;
  logic            a_rst_n = 1'b0;
  logic            enable = 1'b1;
  logic [1:0]      ratio_sel = 2'd0;
  logic            flush = 1'b0;
  logic [M*GS-1:0] znz_din = '0;
  logic [GS*DW-1:0] act_din = '0;
  logic            in_vld_i = 1'b0;
  logic            in_rdy_o;
  logic [VW-1:0]   act_enc_dout;
  logic            act_enc_vld_o;
  logic            act_enc_rdy_i = 1'b1;
  logic            ovf_o;

  int total = 0;
  int bad = 0;
  exp_t sb[$];

  zeroskip_merge_pipe #(.M(M), .DATA_W(DW), .GROUP_SIZE(GS), .GROUP_NZ_MAX(NZ)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .enable(enable), .ratio_sel(ratio_sel), .flush(flush),
    .znz_din(znz_din), .act_din(act_din), .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o),
    .act_enc_dout(act_enc_dout), .act_enc_vld_o(act_enc_vld_o),
    .act_enc_rdy_i(act_enc_rdy_i), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [M*GS-1:0] rm(input int r, input logic [GS-1:0] m);
    logic [M-1:0][GS-1:0] v;
    v = '0;
    v[r] = m;
    return v;
  endfunction

  function automatic logic [GS*DW-1:0] ramp(input logic [DW-1:0] base);
    logic [GS-1:0][DW-1:0] a;
    for (int j = 0; j < GS; j++) a[j] = base + DW'(j);
    return a;
  endfunction

  task automatic push(input vec_t d, input logic o);
    exp_t e;
    e.d = d;
    e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic send(input logic [M*GS-1:0] z, input logic [GS*DW-1:0] a,
                      input logic [1:0] rs, input logic fl);
    logic r;
    bit done;
    done = 0;
    znz_din = z; act_din = a; ratio_sel = rs; flush = fl; in_vld_i = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk); r = in_rdy_o;
      @(posedge clk); #1;
      if (r) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout: in_rdy_o never rose");
    end
    in_vld_i = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // Monitor: a transfer happens at the next edge when valid, ready and enable are all high.
  initial begin
    vec_t got;
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_rst_n && enable && act_enc_vld_o && act_enc_rdy_i) begin
        got = act_enc_dout;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_vector: got=%h want=none", got);
        end else begin
          e = sb.pop_front();
          chk("vector_data", got, e.d);
          chk("vector_ovf", VW'(ovf_o), VW'(e.ovf));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_vld", VW'(act_enc_vld_o), VW'(0));
    chk("reset_rdy", VW'(in_rdy_o), VW'(0));
    chk("reset_dout", act_enc_dout, '0);
    chk("reset_ovf", VW'(ovf_o), VW'(0));
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    idle(1);

    // Mode 0, several rows, exactly K non-zeros in row 2
    e = '0;
    e[0] = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    e[1] = {8'd0, 8'd0, 8'd0, 8'd0, 8'd16, 8'd15, 8'd14, 8'd13};
    e[2] = {8'd12, 8'd11, 8'd10, 8'd9, 8'd4, 8'd3, 8'd2, 8'd1};
    push(e, 1'b0);
    send(rm(0, 16'h00FF) | rm(1, 16'hF000) | rm(2, 16'h0F0F), ramp(8'd1), 2'd0, 1'b0);

    // Reserved mode 3 acts as mode 0; nine non-zeros overflow
    e = '0;
    e[5] = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    push(e, 1'b1);
    send(rm(5, 16'h01FF), ramp(8'd1), 2'd3, 1'b0);

    // Mode 1, two beats; ratio_sel change on beat 1 must be ignored
    e = '0;
    e[0] = {8'h00, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00, 8'h11, 8'h10};
    push(e, 1'b0);
    send(rm(0, 16'h0003), ramp(8'h10), 2'd1, 1'b0);
    send(rm(0, 16'h8000), ramp(8'h10), 2'd0, 1'b0);

    // Mode 2, row 3 has three non-zeros per beat with K=2
    e = '0;
    e[3] = {8'h32, 8'h31, 8'h22, 8'h21, 8'h12, 8'h11, 8'h02, 8'h01};
    push(e, 1'b1);
    for (int b = 0; b < 4; b++) send(rm(3, 16'h0007), ramp(DW'(b * 16 + 1)), 2'd2, 1'b0);

    // Mode 1, one beat then flush; next vector starts fresh
    e = '0;
    e[0] = {8'd0, 8'd0, 8'd0, 8'd0, 8'd8, 8'd7, 8'd6, 8'd5};
    push(e, 1'b0);
    send(rm(0, 16'h00F0), ramp(8'd1), 2'd1, 1'b0);
    pulse_flush();
    e = '0;
    e[0] = {8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd1};
    push(e, 1'b0);
    send(rm(0, 16'h0001), ramp(8'd1), 2'd1, 1'b0);
    send(rm(0, 16'h0002), ramp(8'd1), 2'd1, 1'b0);
    idle(1);

    // Flush with nothing buffered is ignored
    pulse_flush();
    idle(1);

    // Flush together with a mid-vector beat is deferred one cycle
    e = '0;
    e[0][0] = 8'd1;
    push(e, 1'b0);
    send(rm(0, 16'h0001), ramp(8'd1), 2'd2, 1'b1);
    idle(2);

    // Flush with a completing beat is dropped
    e = '0;
    e[0][0] = 8'h50;
    push(e, 1'b0);
    send(rm(0, 16'h0001), ramp(8'h50), 2'd0, 1'b1);
    idle(2);

    // Backpressure: output held three cycles
    e = '0; e[0][0] = 8'h31; push(e, 1'b0);
    e = '0; e[0][0] = 8'h32; push(e, 1'b0);
    e = '0; e[0][0] = 8'h33; push(e, 1'b0);
    send(rm(0, 16'h0001), ramp(8'h31), 2'd0, 1'b0);
    act_enc_rdy_i = 1'b0;
    fork
      begin
        send(rm(0, 16'h0002), ramp(8'h31), 2'd0, 1'b0);
        send(rm(0, 16'h0004), ramp(8'h31), 2'd0, 1'b0);
      end
      begin
        vec_t h;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          h = act_enc_dout;
          chk("hold_rdy", VW'(in_rdy_o), VW'(0));
          chk("hold_dout", VW'(h[0][0]), VW'(8'h31));
          @(posedge clk); #1;
        end
        act_enc_rdy_i = 1'b1;
      end
    join
    idle(2);

    // enable=0 freezes a pending output
    e = '0; e[7][0] = 8'h6F; push(e, 1'b0);
    send(rm(7, 16'h8000), ramp(8'h60), 2'd0, 1'b0);
    enable = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("freeze_vld", VW'(act_enc_vld_o), VW'(1));
      chk("freeze_rdy", VW'(in_rdy_o), VW'(0));
      @(posedge clk); #1;
    end
    enable = 1'b1;
    idle(2);

    // Reset after two of four mode-2 beats discards the partial vector
    send(rm(0, 16'h0001), ramp(8'h77), 2'd2, 1'b0);
    send(rm(0, 16'h0001), ramp(8'h78), 2'd2, 1'b0);
    a_rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("midreset_vld", VW'(act_enc_vld_o), VW'(0));
      chk("midreset_rdy", VW'(in_rdy_o), VW'(0));
      @(posedge clk); #1;
    end
    a_rst_n = 1'b1;
    idle(1);
    @(negedge clk);
    chk("postreset_vld", VW'(act_enc_vld_o), VW'(0));
    @(posedge clk); #1;
    e = '0;
    e[0] = {8'h00, 8'h35, 8'h00, 8'h25, 8'h00, 8'h15, 8'h00, 8'h05};
    push(e, 1'b0);
    for (int b = 0; b < 4; b++) send(rm(0, 16'h0001), ramp(DW'(b * 16 + 5)), 2'd2, 1'b0);

    // Drain
    for (int c = 0; c < 20 && sb.size() != 0; c++) idle(1);
    idle(2);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got=%0d pending want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
